button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, four-state debounce FSM
// with a stability counter, and registered level / rise / fall strobes.
module button_conditioner #(
  parameter int CNT_MAX = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  // Counter only ever needs to reach CNT_MAX-1.
  localparam int            CW       = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_level;
  logic          w_level_nxt;
  logic          r_rise;
  logic          w_rise_nxt;
  logic          r_fall;
  logic          w_fall_nxt;

  // Two-flop synchronizer; only r_sync2 feeds the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic; strobes and level are computed here and registered
  // so nothing combinational reaches the outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (r_sync2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!r_sync2) begin
          // Bounce: drop back without any strobe.
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!r_sync2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_LO: begin
        if (r_sync2) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and output registers; reset aborts any pending change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign level      = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with CNT_MAX=4.
// Expected strobes are queued (cycle + kind) when stimulus is driven and
// popped by the monitor when the DUT emits a strobe.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic btn_raw;
  logic level;
  logic rise_pulse;
  logic fall_pulse;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_rise = 0;
  int n_fall = 0;
  logic prev_level = 1'b0;
  bit   mon_en = 1'b0;

  int exp_cyc[$];
  bit exp_fall[$];

  // Input sampled at edge E0 shows up on the outputs after edge E0+6,
  // which is observed on the negedge where cyc == drive_cyc + 7.
  localparam int LAT = 7;

  button_conditioner #(.CNT_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rise_pulse === 1'b1 || fall_pulse === 1'b1) begin
        if (rise_pulse === 1'b1) n_rise++;
        if (fall_pulse === 1'b1) n_fall++;
        total++;
        if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
          bad++;
          $display("FAIL pulse_overlap cyc=%0d rise=%b fall=%b want not both", cyc, rise_pulse, fall_pulse);
        end
        total++;
        if (exp_cyc.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b want none", cyc, rise_pulse, fall_pulse);
        end else begin
          int  ec;
          bit  ef;
          ec = exp_cyc.pop_front();
          ef = exp_fall.pop_front();
          if (ec !== cyc || ef !== fall_pulse) begin
            bad++;
            $display("FAIL pulse_match got cyc=%0d fall=%b want cyc=%0d fall=%b", cyc, fall_pulse, ec, ef);
          end
        end
      end
      if (exp_cyc.size() != 0 && exp_cyc[0] < cyc) begin
        int  ec;
        bit  ef;
        ec = exp_cyc.pop_front();
        ef = exp_fall.pop_front();
        total++;
        bad++;
        $display("FAIL missed_pulse got none at cyc=%0d want fall=%b at cyc=%0d", cyc, ef, ec);
      end
      if (level !== prev_level) begin
        total++;
        if (!(rise_pulse === 1'b1 || fall_pulse === 1'b1)) begin
          bad++;
          $display("FAIL level_without_pulse cyc=%0d got level=%b want %b", cyc, level, prev_level);
        end
      end
      prev_level = level;
    end
  end

  task automatic expect_pulse(input bit is_fall);
    exp_cyc.push_back(cyc + LAT);
    exp_fall.push_back(is_fall);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    total++;
    if ({level, rise_pulse, fall_pulse} !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000", {level, rise_pulse, fall_pulse});
    end
    // Button already high when reset releases: treated as a fresh press.
    rst = 1'b0;
    expect_pulse(1'b0);
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (level !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_early got level=%b want 0", level);
    end
    @(negedge clk);
    total++;
    if (level !== 1'b1 || rise_pulse !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_rise got level=%b rise=%b want 1 1", level, rise_pulse);
    end
    btn_raw = 1'b0;
    expect_pulse(1'b1);
    repeat (10) @(negedge clk);
    total++;
    if (level !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_back_low got level=%b want 0", level);
    end
  endtask

  task automatic test_clean_press();
    btn_raw = 1'b1;
    expect_pulse(1'b0);
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (level !== 1'b0 || rise_pulse !== 1'b0) begin
      bad++;
      $display("FAIL press_early got level=%b rise=%b want 0 0", level, rise_pulse);
    end
    @(negedge clk);
    total++;
    if (level !== 1'b1 || rise_pulse !== 1'b1 || fall_pulse !== 1'b0) begin
      bad++;
      $display("FAIL press_edge got level=%b rise=%b fall=%b want 1 1 0", level, rise_pulse, fall_pulse);
    end
    @(negedge clk);
    total++;
    if (level !== 1'b1 || rise_pulse !== 1'b0) begin
      bad++;
      $display("FAIL press_after got level=%b rise=%b want 1 0", level, rise_pulse);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_release();
    btn_raw = 1'b0;
    expect_pulse(1'b1);
    repeat (LAT - 1) @(negedge clk);
    total++;
    if (level !== 1'b1 || fall_pulse !== 1'b0) begin
      bad++;
      $display("FAIL release_early got level=%b fall=%b want 1 0", level, fall_pulse);
    end
    @(negedge clk);
    total++;
    if (level !== 1'b0 || fall_pulse !== 1'b1 || rise_pulse !== 1'b0) begin
      bad++;
      $display("FAIL release_edge got level=%b fall=%b rise=%b want 0 1 0", level, fall_pulse, rise_pulse);
    end
    @(negedge clk);
    total++;
    if (fall_pulse !== 1'b0) begin
      bad++;
      $display("FAIL release_after got fall=%b want 0", fall_pulse);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_bounce();
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      btn_raw = pat[i];
      @(negedge clk);
    end
    btn_raw = 1'b1;
    expect_pulse(1'b0);
    repeat (LAT + 3) @(negedge clk);
    total++;
    if (level !== 1'b1) begin
      bad++;
      $display("FAIL bounce_level got level=%b want 1", level);
    end
    btn_raw = 1'b0;
    expect_pulse(1'b1);
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic test_glitch();
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (level !== 1'b0) begin
      bad++;
      $display("FAIL glitch_level got level=%b want 0", level);
    end
  endtask

  task automatic test_reset_mid_wait();
    // WAIT_HI with counter=2 is the state after edge E0+4.
    btn_raw = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({level, rise_pulse, fall_pulse} !== 3'b000) begin
      bad++;
      $display("FAIL midwait_reset got=%b want=000", {level, rise_pulse, fall_pulse});
    end
    rst = 1'b0;
    expect_pulse(1'b0);
    @(negedge clk);
    total++;
    if (rise_pulse !== 1'b0) begin
      bad++;
      $display("FAIL midwait_aborted got rise=%b want 0", rise_pulse);
    end
    repeat (LAT - 2) @(negedge clk);
    total++;
    if (level !== 1'b0) begin
      bad++;
      $display("FAIL midwait_early got level=%b want 0", level);
    end
    @(negedge clk);
    total++;
    if (level !== 1'b1 || rise_pulse !== 1'b1) begin
      bad++;
      $display("FAIL midwait_rise got level=%b rise=%b want 1 1", level, rise_pulse);
    end
    btn_raw = 1'b0;
    expect_pulse(1'b1);
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int r0;
    int f0;
    r0 = n_rise;
    f0 = n_fall;
    for (int i = 0; i < 10; i++) begin
      btn_raw = 1'b1;
      expect_pulse(1'b0);
      repeat (LAT + 2) @(negedge clk);
      btn_raw = 1'b0;
      expect_pulse(1'b1);
      repeat (LAT + 2) @(negedge clk);
    end
    total++;
    if (n_rise - r0 !== 10 || n_fall - f0 !== 10) begin
      bad++;
      $display("FAIL pulse_count got rise=%0d fall=%0d want 10 10", n_rise - r0, n_fall - f0);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_glitch();
    test_reset_mid_wait();
    test_back_to_back();
    repeat (3) @(negedge clk);
    total++;
    if (exp_cyc.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_cyc.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
